// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline hazard sources and the pipeline controller.
// The master side raises stall/flush requests; the slave side is pipe_ctrl.
interface pipe_ctrl_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        ex_done;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [15:0] stall_cnt;
    logic        timeout_err;

    modport master (
        output stallreq_id, stallreq_ex, ex_done, flush_req, flush_pc,
        input  stall, flush, new_pc, stall_cnt, timeout_err
    );

    modport slave (
        input  stallreq_id, stallreq_ex, ex_done, flush_req, flush_pc,
        output stall, flush, new_pc, stall_cnt, timeout_err
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use and multi-cycle EX stalls, redirect flushes,
// a watchdog on multi-cycle operations and a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter logic [7:0] WD_LIMIT = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave pif
);
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MC_WAIT = 2'b01,
        FLUSH   = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  wdCnt_q, wdCnt_d;
    logic [31:0] newPc_q, newPc_d;
    logic [15:0] stallCnt_q, stallCnt_d;
    logic        timeoutErr_q, timeoutErr_d;
    logic [5:0]  stallVec;
    logic [5:0]  stallOut;
    logic        flushOut;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            wdCnt_q      <= 8'd0;
            newPc_q      <= 32'h0;
            stallCnt_q   <= 16'd0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wdCnt_q      <= wdCnt_d;
            newPc_q      <= newPc_d;
            stallCnt_q   <= stallCnt_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    // A redirect always wins; any flush_req sampled here lands in FLUSH next cycle.
    always_comb begin
        state_d      = RUN;
        wdCnt_d      = wdCnt_q;
        newPc_d      = newPc_q;
        timeoutErr_d = timeoutErr_q;
        stallVec     = 6'b000000;
        flushOut     = 1'b0;
        case (state_q)
            RUN: begin
                if (pif.flush_req) begin
                    state_d = FLUSH;
                    newPc_d = pif.flush_pc;
                end else if (pif.stallreq_ex) begin
                    state_d  = MC_WAIT;
                    wdCnt_d  = 8'd0;
                    stallVec = 6'b001111;
                end else if (pif.stallreq_id) begin
                    stallVec = 6'b000111;
                end
            end
            MC_WAIT: begin
                wdCnt_d = wdCnt_q + 8'd1;
                if (pif.flush_req) begin
                    state_d = FLUSH;
                    newPc_d = pif.flush_pc;
                end else if (pif.ex_done) begin
                    state_d = RUN;
                end else if (wdCnt_q == WD_LIMIT) begin
                    state_d      = RUN;
                    timeoutErr_d = 1'b1;
                end else begin
                    state_d  = MC_WAIT;
                    stallVec = 6'b001111;
                end
            end
            FLUSH: begin
                flushOut = 1'b1;
                if (pif.flush_req) begin
                    state_d = FLUSH;
                    newPc_d = pif.flush_pc;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Reset forces the freeze and flush outputs quiet regardless of the current state.
    always_comb begin
        stallOut   = rst ? 6'b000000 : stallVec;
        stallCnt_d = stallCnt_q;
        if (stallOut[0] && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    assign pif.stall       = stallOut;
    assign pif.flush       = flushOut & ~rst;
    assign pif.new_pc      = newPc_q;
    assign pif.stall_cnt   = stallCnt_q;
    assign pif.timeout_err = timeoutErr_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one instance with a long watchdog, one with WD_LIMIT=4,
// both fed the same stimulus.
module tb_pipe_ctrl;
    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;

    pipe_ctrl_if mainIf ();
    pipe_ctrl_if wdIf ();

    pipe_ctrl #(.WD_LIMIT(8'd255)) dut (
        .clk (clk),
        .rst (rst),
        .pif (mainIf)
    );

    pipe_ctrl #(.WD_LIMIT(8'd4)) dutWd (
        .clk (clk),
        .rst (rst),
        .pif (wdIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change just after a rising edge; the caller checks at the following falling edge.
    task automatic applyStimulus(input logic id, input logic ex, input logic done,
                                 input logic fr, input logic [31:0] pc);
        @(posedge clk);
        #1;
        mainIf.stallreq_id = id;
        mainIf.stallreq_ex = ex;
        mainIf.ex_done     = done;
        mainIf.flush_req   = fr;
        mainIf.flush_pc    = pc;
        wdIf.stallreq_id   = id;
        wdIf.stallreq_ex   = ex;
        wdIf.ex_done       = done;
        wdIf.flush_req     = fr;
        wdIf.flush_pc      = pc;
        @(negedge clk);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst = 1'b1;
        mainIf.stallreq_id = 1'b0;
        mainIf.stallreq_ex = 1'b0;
        mainIf.ex_done     = 1'b0;
        mainIf.flush_req   = 1'b0;
        mainIf.flush_pc    = 32'h0;
        wdIf.stallreq_id   = 1'b0;
        wdIf.stallreq_ex   = 1'b0;
        wdIf.ex_done       = 1'b0;
        wdIf.flush_req     = 1'b0;
        wdIf.flush_pc      = 32'h0;

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h1234);
        checkOutput("rstStall", {26'd0, mainIf.stall}, 32'h0);
        checkOutput("rstFlush", {31'd0, mainIf.flush}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rstNewPc", mainIf.new_pc, 32'h0);
        checkOutput("rstStallCnt", {16'd0, mainIf.stall_cnt}, 32'h0);
        checkOutput("rstTimeout", {31'd0, mainIf.timeout_err}, 32'h0);
        checkOutput("rstFlushAfter", {31'd0, mainIf.flush}, 32'h0);
        rst = 1'b0;

        // One-cycle load-use stall
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("idStall", {26'd0, mainIf.stall}, 32'h07);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("idStallEnd", {26'd0, mainIf.stall}, 32'h0);
        checkOutput("idStallCnt", {16'd0, mainIf.stall_cnt}, 32'd1);

        // Multi-cycle op finishing after 5 wait cycles
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("exReqStall", {26'd0, mainIf.stall}, 32'h0F);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput("exWaitStall", {26'd0, mainIf.stall}, 32'h0F);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("exDoneStall", {26'd0, mainIf.stall}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("exAfterStall", {26'd0, mainIf.stall}, 32'h0);
        checkOutput("exStallCnt", {16'd0, mainIf.stall_cnt}, 32'd7);

        // Flush arriving during a multi-cycle op
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("mcWaitStall", {26'd0, mainIf.stall}, 32'h0F);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC00380);
        checkOutput("mcFlushReqStall", {26'd0, mainIf.stall}, 32'h0);
        checkOutput("mcFlushReqFlush", {31'd0, mainIf.flush}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("mcFlush", {31'd0, mainIf.flush}, 32'h1);
        checkOutput("mcNewPc", mainIf.new_pc, 32'hBFC00380);
        checkOutput("mcFlushStall", {26'd0, mainIf.stall}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("mcFlushEnd", {31'd0, mainIf.flush}, 32'h0);
        checkOutput("mcNewPcHold", mainIf.new_pc, 32'hBFC00380);
        checkOutput("mcStallCnt", {16'd0, mainIf.stall_cnt}, 32'd10);

        // Back-to-back flushes
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
        checkOutput("b2bFlush1", {31'd0, mainIf.flush}, 32'h1);
        checkOutput("b2bPc1", mainIf.new_pc, 32'h100);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("b2bFlush2", {31'd0, mainIf.flush}, 32'h1);
        checkOutput("b2bPc2", mainIf.new_pc, 32'h200);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("b2bFlushEnd", {31'd0, mainIf.flush}, 32'h0);

        // ex_done outside MC_WAIT has no effect
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("doneRunStall", {26'd0, mainIf.stall}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("doneRunFlush", {31'd0, mainIf.flush}, 32'h0);

        // All requests together: the flush wins
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h300);
        checkOutput("prioStall", {26'd0, mainIf.stall}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("prioFlush", {31'd0, mainIf.flush}, 32'h1);
        checkOutput("prioNewPc", mainIf.new_pc, 32'h300);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("prioRunStall", {26'd0, mainIf.stall}, 32'h0);
        checkOutput("prioStallCnt", {16'd0, mainIf.stall_cnt}, 32'd10);

        // Reset in the middle of MC_WAIT
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("rstMcStall", {26'd0, mainIf.stall}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rstMcAfterStall", {26'd0, mainIf.stall}, 32'h0);
        checkOutput("rstMcStallCnt", {16'd0, mainIf.stall_cnt}, 32'd0);

        // Reset in the middle of FLUSH
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h400);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("preRstFlush", {31'd0, mainIf.flush}, 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("rstFlFlush", {31'd0, mainIf.flush}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rstFlAfterFlush", {31'd0, mainIf.flush}, 32'h0);
        checkOutput("rstFlNewPc", mainIf.new_pc, 32'h0);

        // Watchdog trip on the WD_LIMIT=4 instance
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("wdReqStall", {26'd0, wdIf.stall}, 32'h0F);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput("wdWaitStall", {26'd0, wdIf.stall}, 32'h0F);
            checkOutput("wdWaitTimeout", {31'd0, wdIf.timeout_err}, 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("wdTripStall", {26'd0, wdIf.stall}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("wdTimeout", {31'd0, wdIf.timeout_err}, 32'h1);
        checkOutput("wdRunStall", {26'd0, wdIf.stall}, 32'h0);
        checkOutput("wdStallCnt", {16'd0, wdIf.stall_cnt}, 32'd5);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        checkOutput("wdTimeoutSticky", {31'd0, wdIf.timeout_err}, 32'h1);

        // Saturation: keep the long-watchdog instance stalled for 70000 cycles
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        checkOutput("satStallCnt", {16'd0, mainIf.stall_cnt}, 32'h0000FFFF);
        checkOutput("satTimeout", {31'd0, mainIf.timeout_err}, 32'h1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("satRstStallCnt", {16'd0, mainIf.stall_cnt}, 32'h0);
        checkOutput("satRstTimeout", {31'd0, mainIf.timeout_err}, 32'h0);
        checkOutput("satRstWdCnt", {16'd0, wdIf.stall_cnt}, 32'h0);
        checkOutput("satRstStall", {26'd0, mainIf.stall}, 32'h0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have the parameter WD_LIMIT, default 8'd255, the maximum number of MC_WAIT cycles before the watchdog trips.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port stallreq_id, input, 1 bit: ID-stage load-use hazard, one-cycle stall request.
REQ-005 The block SHALL have the port stallreq_ex, input, 1 bit: EX stage starting a multi-cycle operation (mul/div).
REQ-006 The block SHALL have the port ex_done, input, 1 bit: the multi-cycle EX operation completes this cycle.
REQ-007 The block SHALL have the port flush_req, input, 1 bit: exception/redirect request.
REQ-008 The block SHALL have the port flush_pc, input, 32 bits: redirect target, valid with flush_req.
REQ-009 The block SHALL have the port stall, output, 6 bits: freeze vector; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved and always 0.
REQ-010 The block SHALL have the port flush, output, 1 bit: clear all pipeline registers and load new_pc.
REQ-011 The block SHALL have the port new_pc, output, 32 bits: registered redirect target.
REQ-012 The block SHALL have the port stall_cnt, output, 16 bits: count of cycles with stall[0]=1.
REQ-013 The block SHALL have the port timeout_err, output, 1 bit: sticky watchdog error flag.

Function
REQ-014 The FSM SHALL have the states RUN, MC_WAIT and FLUSH, encoded in 2 bits; the unused encoding SHALL go to RUN on the next cycle.
REQ-015 stall SHALL be combinational from the state and the inputs.
REQ-016 In RUN, stall SHALL be selected by this priority: flush_req -> 6'b000000; else stallreq_ex -> 6'b001111; else stallreq_id -> 6'b000111; else 6'b000000.
REQ-017 In RUN: flush_req SHALL move the FSM to FLUSH and capture flush_pc into new_pc; else stallreq_ex SHALL move it to MC_WAIT and clear the watchdog counter; else it SHALL stay in RUN.
REQ-018 stallreq_id SHALL NOT change the state; the stall lasts only while the input is high.
REQ-019 In MC_WAIT, stall SHALL be 6'b001111 and the 8-bit watchdog counter SHALL increment each cycle.
REQ-020 MC_WAIT exits SHALL have this priority: flush_req -> FLUSH (captures flush_pc, aborts the op, stall=0 that cycle); else ex_done -> RUN (stall=0 that cycle); else counter==WD_LIMIT -> RUN with timeout_err set (stall=0 that cycle).
REQ-021 In FLUSH, flush SHALL be 1 and stall SHALL be 0 for exactly one cycle, then the FSM SHALL go to RUN.
REQ-022 A flush_req arriving while in FLUSH SHALL re-enter FLUSH with the new flush_pc, giving back-to-back flushes.
REQ-023 flush SHALL be asserted only in FLUSH, i.e. one cycle after flush_req is sampled.
REQ-024 new_pc SHALL hold its value between captures.
REQ-025 stall_cnt SHALL increment on every cycle with stall[0]=1 and SHALL saturate at 16'hFFFF with no wrap.
REQ-026 timeout_err, once set, SHALL remain 1 until rst.
REQ-027 ex_done sampled in RUN or FLUSH SHALL be ignored.

Reset
REQ-028 While rst=1 at a clock edge, the next state SHALL be: state=RUN, watchdog counter=0, new_pc=32'h0, stall_cnt=0, timeout_err=0.
REQ-029 While rst=1, the outputs SHALL be stall=0 and flush=0, regardless of the other inputs.
REQ-030 Reset asserted mid-MC_WAIT or mid-FLUSH SHALL abort the operation with no residual flush or stall.

Verification
REQ-031 The bench SHALL cover: stallreq_id=1 for 1 cycle in RUN -> stall=6'b000111 that cycle only, state stays RUN, stall_cnt=1.
REQ-032 The bench SHALL cover: stallreq_ex pulse, ex_done 5 cycles later -> stall=6'b001111 for 6 cycles (request cycle plus 5 wait cycles), 0 on the ex_done cycle, stall_cnt=6.
REQ-033 The bench SHALL cover: flush_req=1 with flush_pc=32'hBFC00380 in MC_WAIT -> stall=0 that cycle; next cycle flush=1, new_pc=32'hBFC00380; then RUN.
REQ-034 The bench SHALL cover: stallreq_ex, stallreq_id and flush_req all high in RUN -> stall=0 and FLUSH next cycle (flush priority).
REQ-035 The bench SHALL cover: stallreq_ex with ex_done never asserted, WD_LIMIT=8'd4 -> after 4 wait cycles, stall=0 and RUN with timeout_err=1, still 1 after 10 more idle cycles.
REQ-036 The bench SHALL cover: stall_cnt preloaded near saturation by holding MC_WAIT with ex_done low for 70000 cycles and WD_LIMIT large -> stall_cnt=16'hFFFF with no wrap; rst=1 -> all counters 0.
